exposure_timer_ctrl: RTL and testbench

Programmable exposure-time controller for the pixel camera. It holds the user exposure setting, adjusted by increment/decrement buttons and clamped to a legal range. On an Init request it runs an exposure countdown and drives the exposure start and overflow signals that the camera readout state machine consumes. It also stops new exposures and setting changes until readout (Busy) completes.

---
 rtl/exposure_timer_ctrl.sv | 92 +++++++++
 tb/tb_exposure_timer_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/exposure_timer_ctrl.sv
// exposure_timer_ctrl: clamped exposure setting with Init-triggered countdown, Ovf pulse and readout lockout
module exposure_timer_ctrl #(
  parameter int WIDTH     = 5,
  parameter int MIN_T     = 2,
  parameter int MAX_T     = 30,
  parameter int DEFAULT_T = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Exp_inc,
  input  logic             Exp_dec,
  input  logic             Init,
  input  logic             Busy,
  output logic             Expose_start,
  output logic             Exposing,
  output logic             Ovf,
  output logic [WIDTH-1:0] Exp_time,
  output logic [WIDTH-1:0] Count
);
  typedef enum logic [1:0] {IDLE, EXPOSE, WAIT} state_t;
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_T);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_T);
  localparam logic [WIDTH-1:0] DEF_V = WIDTH'(DEFAULT_T);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_time_q, exp_time_d, count_q, count_d;
  logic             start_q, start_d, exposing_q, exposing_d, ovf_q, ovf_d;
  logic             inc_prev_q, dec_prev_q, init_prev_q;
  logic             inc_edge, dec_edge, init_edge;
  assign inc_edge  = Exp_inc & ~inc_prev_q;
  assign dec_edge  = Exp_dec & ~dec_prev_q;
  assign init_edge = Init & ~init_prev_q;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      exp_time_q  <= DEF_V;
      count_q     <= '0;
      start_q     <= 1'b0;
      exposing_q  <= 1'b0;
      ovf_q       <= 1'b0;
      inc_prev_q  <= 1'b1;
      dec_prev_q  <= 1'b1;
      init_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      exp_time_q  <= exp_time_d;
      count_q     <= count_d;
      start_q     <= start_d;
      exposing_q  <= exposing_d;
      ovf_q       <= ovf_d;
      inc_prev_q  <= Exp_inc;
      dec_prev_q  <= Exp_dec;
      init_prev_q <= Init;
    end
  end
  // Ovf_q is high only during the first WAIT cycle, so it doubles as the residency guard
  always_comb begin
    state_d    = state_q;
    exp_time_d = exp_time_q;
    count_d    = count_q;
    start_d    = 1'b0;
    exposing_d = exposing_q;
    ovf_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (inc_edge && !dec_edge && exp_time_q < MAX_V) exp_time_d = exp_time_q + ONE_V;
        if (dec_edge && !inc_edge && exp_time_q > MIN_V) exp_time_d = exp_time_q - ONE_V;
        if (init_edge && !Busy) begin
          state_d    = EXPOSE;
          count_d    = exp_time_q;
          exposing_d = 1'b1;
          start_d    = 1'b1;
        end
      end
      EXPOSE: begin
        count_d = count_q - ONE_V;
        if (count_q == ONE_V) begin
          exposing_d = 1'b0;
          ovf_d      = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: state_d = (!ovf_q && !Busy) ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  assign Expose_start = start_q;
  assign Exposing     = exposing_q;
  assign Ovf          = ovf_q;
  assign Exp_time     = exp_time_q;
  assign Count        = count_q;
endmodule

// File: tb/tb_exposure_timer_ctrl.sv
// tb_exposure_timer_ctrl: vector table, corner sequences and random traffic against a timeline model
module tb_exposure_timer_ctrl;
  localparam int MIN_T = 2, MAX_T = 30, DEF_T = 15;
  logic       Clk = 1'b0, Reset = 1'b1;
  logic       Exp_inc = 1'b0, Exp_dec = 1'b0, Init = 1'b0, Busy = 1'b0;
  logic       Expose_start, Exposing, Ovf;
  logic [4:0] Exp_time, Count;
  int n_tests = 0, n_fail = 0;
  exposure_timer_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Exp_inc(Exp_inc), .Exp_dec(Exp_dec), .Init(Init), .Busy(Busy),
    .Expose_start(Expose_start), .Exposing(Exposing), .Ovf(Ovf), .Exp_time(Exp_time), .Count(Count)
  );
  always #5 Clk = ~Clk;
  // model: exposure described by its start edge and length; outputs derived from elapsed edges
  int m_exp, m_t, m_start, m_edge = 0;
  bit m_lock, m_pi, m_pd, m_pn;
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_exp = DEF_T; m_t = 0; m_start = -1; m_lock = 0;
    m_pi = 1; m_pd = 1; m_pn = 1;
  endtask
  task automatic model_edge(input bit inc, input bit dec, input bit init, input bit busy);
    bit ie, de, ne;
    ie = inc && !m_pi; de = dec && !m_pd; ne = init && !m_pn;
    if (m_lock) begin
      if (m_edge - m_start >= m_t + 2 && !busy) m_lock = 0;
    end else begin
      if (ne && !busy) begin m_lock = 1; m_start = m_edge; m_t = m_exp; end
      if (ie && !de && m_exp < MAX_T) m_exp++;
      if (de && !ie && m_exp > MIN_T) m_exp--;
    end
    m_pi = inc; m_pd = dec; m_pn = init;
    m_edge++;
  endtask
  task automatic check_model();
    int t;
    t = (m_start < 0) ? 1 << 20 : (m_edge - 1) - m_start;
    chk("m_exp_time", int'(Exp_time), m_exp);
    chk("m_exposing", int'(Exposing), int'(t < m_t));
    chk("m_count", int'(Count), t < m_t ? m_t - t : 0);
    chk("m_start", int'(Expose_start), int'(t == 0));
    chk("m_ovf", int'(Ovf), int'(t == m_t));
  endtask
  task automatic cyc(input bit inc, input bit dec, input bit init, input bit busy);
    Exp_inc = inc; Exp_dec = dec; Init = init; Busy = busy;
    model_edge(inc, dec, init, busy);
    @(posedge Clk); #1;
    check_model();
  endtask
  typedef struct {bit inc; bit dec; bit init; bit busy; int et; bit ex; int cnt;} vec_t;
  vec_t vt[11];
  int exp_cnt[7] = '{5, 4, 3, 2, 1, 0, 0};
  initial begin
    bit b;
    vt[0]  = '{1, 0, 0, 0, 16, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 16, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 16, 0, 0};
    vt[3]  = '{0, 1, 0, 0, 15, 0, 0};
    vt[4]  = '{0, 0, 0, 0, 15, 0, 0};
    vt[5]  = '{1, 1, 0, 0, 15, 0, 0};
    vt[6]  = '{0, 0, 0, 0, 15, 0, 0};
    vt[7]  = '{0, 0, 1, 1, 15, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 15, 0, 0};
    vt[9]  = '{0, 0, 0, 1, 15, 0, 0};
    vt[10] = '{0, 1, 1, 0, 14, 1, 15};
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (5) cyc(0, 0, 0, 0);
    chk("rst_exp_time", int'(Exp_time), 15);
    chk("rst_exposing", int'(Exposing), 0);
    chk("rst_ovf", int'(Ovf), 0);
    chk("rst_count", int'(Count), 0);
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].inc, vt[i].dec, vt[i].init, vt[i].busy);
      chk($sformatf("vec%0d_exp_time", i), int'(Exp_time), vt[i].et);
      chk($sformatf("vec%0d_exposing", i), int'(Exposing), int'(vt[i].ex));
      chk($sformatf("vec%0d_count", i), int'(Count), vt[i].cnt);
    end
    repeat (20) cyc(0, 0, 0, 0);
    repeat (20) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
    chk("clamp_max", int'(Exp_time), 30);
    repeat (40) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
    chk("clamp_min", int'(Exp_time), 2);
    cyc(1, 1, 0, 0); cyc(0, 0, 0, 0);
    chk("inc_dec_same", int'(Exp_time), 2);
    repeat (10) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("inc_held", int'(Exp_time), 3);
    repeat (2) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
    chk("set_five", int'(Exp_time), 5);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, i == 0, 0);
      chk($sformatf("exp%0d_start", i), int'(Expose_start), int'(i == 0));
      chk($sformatf("exp%0d_exposing", i), int'(Exposing), int'(i < 5));
      chk($sformatf("exp%0d_count", i), int'(Count), exp_cnt[i]);
      chk($sformatf("exp%0d_ovf", i), int'(Ovf), int'(i == 5));
    end
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("lock_count", int'(Count), 2);
    chk("lock_start", int'(Expose_start), 0);
    chk("lock_exp_time", int'(Exp_time), 5);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("lock_ovf", int'(Ovf), 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, i % 2 == 0, 1);
      chk("busy_no_start", int'(Exposing), 0);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("restart_start", int'(Expose_start), 1);
    chk("restart_count", int'(Count), 5);
    repeat (10) cyc(0, 0, 0, 0);
    repeat (15) begin cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); end
    chk("set_twenty", int'(Exp_time), 20);
    for (int i = 0; i < 40 && Count != 5'd7; i++) cyc(0, 0, 1, 0);
    chk("reach_count7", int'(Count), 7);
    #2 Reset = 1'b1;
    #1;
    chk("arst_exposing", int'(Exposing), 0);
    chk("arst_count", int'(Count), 0);
    chk("arst_ovf", int'(Ovf), 0);
    chk("arst_exp_time", int'(Exp_time), 15);
    model_reset();
    @(posedge Clk); #1 Reset = 1'b0;
    repeat (5) cyc(0, 0, 1, 0);
    chk("held_init_blocked", int'(Exposing), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("init_after_drop", int'(Expose_start), 1);
    repeat (20) cyc(0, 0, 0, 0);
    b = 0;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) b = ~b;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, b);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
